// File: rtl/mem_access.sv
// Y86-64 memory stage: one 64-bit little-endian read/write on a byte-addressed data memory per Start.
// Latency: Done at t+WAIT_CYCLES+2 for memory ops, t+1 for no-access ops (Start accepted in cycle t).
// Backpressure: Start is sampled only in IDLE; Busy covers the whole operation through the Done cycle.
// Optional MEM_ACCESS_ALIGN_CHECK_EN: when defined, an unaligned address (addr[2:0] != 0) is also an error.
module mem_access #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        Busy,
  output logic        Done,
  output logic        MemError
);

  localparam int          AW        = $clog2(MEM_BYTES);
  // Highest legal start address for an 8-byte access.
  localparam logic [63:0] LAST_OK   = 64'(MEM_BYTES - 8);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  icode_q;
  logic [63:0] valE_q, valA_q, valP_q;
  logic [63:0] valM_q;
  logic        err_q;
  logic        latch_en;

  logic [7:0]  mem_q [MEM_BYTES];

  // Decoded operation of the latched instruction
  logic          is_wr, is_rd, start_mem;
  logic [63:0]   addr, wdata, rd_data;
  logic [AW-1:0] idx;
  logic          addr_err, do_wr, do_rd, in_access;

  // Operation decode from the latched icode; start_mem decodes the live icode for the IDLE branch
  always_comb begin
    is_wr     = (icode_q == 4'h4) || (icode_q == 4'hA) || (icode_q == 4'h8);
    is_rd     = (icode_q == 4'h5) || (icode_q == 4'h9) || (icode_q == 4'hB);
    addr      = ((icode_q == 4'h9) || (icode_q == 4'hB)) ? valA_q : valE_q;
    wdata     = (icode_q == 4'h8) ? valP_q : valA_q;
    start_mem = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8) ||
                (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    idx       = addr[AW-1:0];
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    addr_err  = (addr > LAST_OK) || (addr[2:0] != 3'b000);
`else
    addr_err  = (addr > LAST_OK);
`endif
    in_access = (state_q == S_ACCESS);
    do_wr     = in_access && is_wr && !addr_err;
    do_rd     = in_access && is_rd && !addr_err;
  end

  // Little-endian gather of eight bytes starting at idx (unaligned allowed when in range)
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem_q[idx + AW'(i)];
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) ACCESS -> DONE for memory ops, IDLE -> DONE otherwise
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          latch_en = 1'b1;
          if (start_mem) begin
            if (WAIT_CYCLES > 0) begin
              state_d = S_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = S_ACCESS;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state, operand latches, read result and sticky error; Reset overrides everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      icode_q <= 4'd0;
      valE_q  <= '0;
      valA_q  <= '0;
      valP_q  <= '0;
      valM_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        icode_q <= icode;
        valE_q  <= valE;
        valA_q  <= valA;
        valP_q  <= valP;
      end
      if (do_rd) begin
        valM_q <= rd_data;
      end
      if (in_access && (is_wr || is_rd) && addr_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Data memory write port; contents survive Reset but no write happens on a Reset edge
  always_ff @(posedge Clk) begin
    if (!Reset && do_wr) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  assign valM     = valM_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign MemError = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with MEM_BYTES=1024, WAIT_CYCLES=2.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_mem_access;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic [63:0] valM;
  logic        Busy, Done, MemError;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] VC = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VD = 64'h5555_6666_7777_8888;

  always #5 Clk = ~Clk;

  mem_access #(.MEM_BYTES(1024), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .valM(valM), .Busy(Busy), .Done(Done), .MemError(MemError)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for Done, capture Done-cycle outputs, then step back to IDLE.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, output int lat, output logic [63:0] vm, output logic er);
    icode = ic; valE = e; valA = a; valP = p; Start = 1'b1;
    tick();
    Start = 1'b0; icode = 4'hF; valE = '1; valA = '1; valP = '1;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vm = valM;
    er = MemError;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    tick();
    tick();
    n_checks++; if (valM !== 64'h0) begin n_fail++; $display("FAIL reset_valM: got %h want 0", valM); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (MemError !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", MemError); end
    Reset = 1'b0; Start = 1'b0;
    tick();
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b want 0", Busy); end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] vm; logic er;
    do_op(4'h4, 64'h10, 64'h1122_3344_5566_7788, 64'h0, lat, vm, er);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
    n_checks++; if (dut.mem_q[16] !== 8'h88) begin n_fail++; $display("FAIL wr_byte10: got %h want 88", dut.mem_q[16]); end
    n_checks++; if (dut.mem_q[23] !== 8'h11) begin n_fail++; $display("FAIL wr_byte17: got %h want 11", dut.mem_q[23]); end
    do_op(4'h5, 64'h10, 64'h0, 64'h0, lat, vm, er);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_checks++; if (vm !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL rd_valM: got %h want 1122334455667788", vm); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_call_ret();
    int lat; logic [63:0] vm; logic er;
    do_op(4'h8, 64'h3F8, 64'hDEAD, 64'hABCD, lat, vm, er);
    do_op(4'h9, 64'h0, 64'h3F8, 64'h0, lat, vm, er);
    n_checks++; if (vm !== 64'hABCD) begin n_fail++; $display("FAIL ret_valM: got %h want abcd", vm); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL ret_err: got %b want 0", er); end
    do_op(4'hA, 64'h100, 64'h55AA, 64'h0, lat, vm, er);
    do_op(4'hB, 64'h0, 64'h100, 64'h0, lat, vm, er);
    n_checks++; if (vm !== 64'h55AA) begin n_fail++; $display("FAIL pop_valM: got %h want 55aa", vm); end
  endtask

  task automatic test_range_error();
    int lat; logic [63:0] vm; logic er;
    do_op(4'h5, 64'h3F9, 64'h0, 64'h0, lat, vm, er);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL oor_latency: got %0d want 4", lat); end
    n_checks++; if (vm !== 64'h55AA) begin n_fail++; $display("FAIL oor_valM_held: got %h want 55aa", vm); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", er); end
    do_op(4'h4, 64'h8000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, lat, vm, er);
    n_checks++; if (dut.mem_q[16] !== 8'h88) begin n_fail++; $display("FAIL oor_no_write: got %h want 88", dut.mem_q[16]); end
    do_op(4'h5, 64'h10, 64'h0, 64'h0, lat, vm, er);
    n_checks++; if (vm !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL oor_then_good_valM: got %h", vm); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", er); end
  endtask

  task automatic test_nop();
    icode = 4'h0; valE = 64'h10; valA = 64'h0; valP = 64'h0; Start = 1'b1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy_t: got %b want 0", Busy); end
    tick();
    Start = 1'b0;
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL nop_done_t1: got %b want 1", Done); end
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL nop_busy_t1: got %b want 1", Busy); end
    tick();
    n_checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL nop_t2: done %b busy %b want 0 0", Done, Busy); end
    n_checks++; if (dut.mem_q[16] !== 8'h88) begin n_fail++; $display("FAIL nop_no_write: got %h want 88", dut.mem_q[16]); end
  endtask

  task automatic test_start_ignored();
    icode = 4'h5; valE = 64'h10; Start = 1'b1;
    tick();
    icode = 4'h0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL busy_start_c%0d: done %b want 0", c, Done); end
      tick();
    end
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done_t4: got %b want 1", Done); end
    Start = 1'b0;
    tick();
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: busy %b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    icode = 4'h5; valE = 64'h10; Start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 10) Start = 1'b0;
      exp_done = (c == 4) || (c == 9);
      n_checks++; if (Done !== exp_done) begin n_fail++; $display("FAIL b2b_c%0d: done %b want %b", c, Done, exp_done); end
    end
    tick();
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", Busy); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [63:0] vm; logic er; logic seen_done;
    do_op(4'h4, 64'h40, VA, 64'h0, lat, vm, er);
    icode = 4'h4; valE = 64'h40; valA = VB; Start = 1'b1;
    tick();
    Start = 1'b0; Reset = 1'b1;
    tick();
    n_checks++; if (valM !== 64'h0 || Busy !== 1'b0 || Done !== 1'b0 || MemError !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait_outs: valM %h busy %b done %b err %b want all 0", valM, Busy, Done, MemError);
    end
    Reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin tick(); if (Done === 1'b1) seen_done = 1'b1; end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_wait_no_done: got %b want 0", seen_done); end
    do_op(4'h4, 64'h48, VC, 64'h0, lat, vm, er);
    icode = 4'h4; valE = 64'h48; valA = VD; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_access_busy: got %b want 0", Busy); end
    tick();
    do_op(4'h5, 64'h40, 64'h0, 64'h0, lat, vm, er);
    n_checks++; if (vm !== VA) begin n_fail++; $display("FAIL abort_wait_old: got %h want %h", vm, VA); end
    do_op(4'h5, 64'h48, 64'h0, 64'h0, lat, vm, er);
    n_checks++; if (vm !== VC) begin n_fail++; $display("FAIL abort_access_old: got %h want %h", vm, VC); end
  endtask

  task automatic test_unaligned();
    int lat; logic [63:0] vm; logic er;
    do_op(4'h4, 64'h18, 64'h0807_0605_0403_0201, 64'h0, lat, vm, er);
    do_op(4'h5, 64'h12, 64'h0, 64'h0, lat, vm, er);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL unaligned_err: got %b want 1", er); end
    n_checks++; if (vm !== VC) begin n_fail++; $display("FAIL unaligned_valM_held: got %h want %h", vm, VC); end
`else
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL unaligned_err: got %b want 0", er); end
    n_checks++; if (vm !== 64'h0201_1122_3344_5566) begin n_fail++; $display("FAIL unaligned_valM: got %h want 0201112233445566", vm); end
`endif
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    test_reset();
    test_write_read();
    test_call_ret();
    test_range_error();
    test_nop();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_unaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
